// File: rtl/md_issue_sched.sv
// Issue sequencer for the shared multiply/divide unit: round-robin grant between the
// MUL and DIV reservation stations, fixed-latency timing and CDB result handshake.
module md_issue_sched #(
    parameter int TAG_W            = 6,
    parameter int MUL_LAT          = 3,
    parameter int DIV_LAT          = 33,
    parameter int MD_OP_WIDTH      = 2,
    parameter int MD_OUT_SEL_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mul_req_valid,
    output logic                        mul_req_ready,
    input  logic [TAG_W-1:0]            mul_req_tag,
    input  logic [MD_OP_WIDTH-1:0]      mul_req_op,
    input  logic                        mul_req_in_1_signed,
    input  logic                        mul_req_in_2_signed,
    input  logic [MD_OUT_SEL_WIDTH-1:0] mul_req_out_sel,
    input  logic                        div_req_valid,
    output logic                        div_req_ready,
    input  logic [TAG_W-1:0]            div_req_tag,
    input  logic [MD_OP_WIDTH-1:0]      div_req_op,
    input  logic                        div_req_in_1_signed,
    input  logic                        div_req_in_2_signed,
    input  logic [MD_OUT_SEL_WIDTH-1:0] div_req_out_sel,
    input  logic                        flush,
    output logic                        md_start,
    output logic                        md_kill,
    output logic                        md_src_sel,
    output logic [MD_OP_WIDTH-1:0]      md_req_op,
    output logic                        md_req_in_1_signed,
    output logic                        md_req_in_2_signed,
    output logic [MD_OUT_SEL_WIDTH-1:0] md_req_out_sel,
    output logic                        cdb_valid,
    input  logic                        cdb_ready,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic                        busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             prio;   // 0: MUL side wins a tie, 1: DIV side wins
    logic [CNT_W-1:0] cnt;
    logic             can_accept;
    logic             mul_acc;
    logic             div_acc;

    assign can_accept    = (state == IDLE) && !flush;
    assign mul_req_ready = can_accept && (!div_req_valid || !prio);
    assign div_req_ready = can_accept && (!mul_req_valid || prio);
    assign mul_acc       = mul_req_valid && mul_req_ready;
    assign div_acc       = div_req_valid && div_req_ready;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            prio               <= 1'b0;
            cnt                <= '0;
            md_start           <= 1'b0;
            md_kill            <= 1'b0;
            md_src_sel         <= 1'b0;
            md_req_op          <= '0;
            md_req_in_1_signed <= 1'b0;
            md_req_in_2_signed <= 1'b0;
            md_req_out_sel     <= '0;
            cdb_valid          <= 1'b0;
            cdb_tag            <= '0;
        end else begin
            md_start <= 1'b0;
            md_kill  <= 1'b0;
            if (flush) begin
                // A result handed over in this same cycle counts as broadcast, so no abort.
                state     <= IDLE;
                cdb_valid <= 1'b0;
                md_kill   <= (state == RUN) || ((state == DONE) && !cdb_ready);
            end else begin
                case (state)
                    IDLE: begin
                        if (mul_acc || div_acc) begin
                            state      <= RUN;
                            md_start   <= 1'b1;
                            prio       <= mul_acc;
                            md_src_sel <= div_acc;
                            if (div_acc) begin
                                cnt                <= DIV_CNT;
                                cdb_tag            <= div_req_tag;
                                md_req_op          <= div_req_op;
                                md_req_in_1_signed <= div_req_in_1_signed;
                                md_req_in_2_signed <= div_req_in_2_signed;
                                md_req_out_sel     <= div_req_out_sel;
                            end else begin
                                cnt                <= MUL_CNT;
                                cdb_tag            <= mul_req_tag;
                                md_req_op          <= mul_req_op;
                                md_req_in_1_signed <= mul_req_in_1_signed;
                                md_req_in_2_signed <= mul_req_in_2_signed;
                                md_req_out_sel     <= mul_req_out_sel;
                            end
                        end
                    end
                    RUN: begin
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state     <= DONE;
                            cdb_valid <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (cdb_ready) begin
                            state     <= IDLE;
                            cdb_valid <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
